// File: rtl/four_split_pkg.sv
// Shared definitions for the four_split round-robin dispatcher.
//   NCH    : number of output channels
//   PTR_W  : width of the channel pointer
//   inc_ptr: advance a channel pointer by one, wrapping 3 -> 0
package four_split_pkg;

  localparam int NCH   = 4;
  localparam int PTR_W = 2;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/four_split_slot.sv
// One-entry holding register for a single dispatcher output channel.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of the valid flag (data is kept)
//   load       : capture load_data and mark the slot occupied
//   drain      : consumer took the held word this cycle
//   load_data  : word to capture
//   valid      : slot occupied
//   data       : held word
module split_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // Priority: flush beats load beats drain. A load in the same cycle as a
  // drain keeps the slot occupied with the new word (full throughput).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/four_split.sv
// Round-robin 1-to-4 stream dispatcher. Successive accepted words go to
// channels 0,1,2,3,0,... each channel holding one word until its consumer
// takes it.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear of all slots and the pointer
//   in_valid/in_ready/in_data : input stream handshake
//   out_valid[i]/out_ready[i]/out_data[i*W +: W] : channel i
//   any_valid   : OR of all channel valids
//   ptr         : channel the next accepted word will go to
//   accept_cnt  : running count of accepted words (wraps)
// SKIP_BUSY=0 stalls on a blocked target channel; SKIP_BUSY=1 steps the
// pointer past a blocked channel one position per cycle.
module four_split
  import four_split_pkg::*;
#(
  parameter int W         = 8,
  parameter int CNT_W     = 8,
  parameter int SKIP_BUSY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [NCH*W-1:0] out_data,
  output logic             any_valid,
  output logic [PTR_W-1:0] ptr,
  output logic [CNT_W-1:0] accept_cnt
);

  localparam bit SKIP = (SKIP_BUSY != 0);

  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sel_valid;
  logic             sel_ready;
  logic             accept;
  logic             blocked;

  assign sel_valid = out_valid[ptr_q];
  assign sel_ready = out_ready[ptr_q];

  // Target slot can take a word if it is empty or being drained this cycle.
  assign in_ready  = ~flush & (~sel_valid | sel_ready);
  assign accept    = in_valid & in_ready;
  assign blocked   = sel_valid & ~sel_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    split_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .load      (accept && (ptr_q == PTR_W'(i))),
      .drain     (out_valid[i] & out_ready[i]),
      .load_data (in_data),
      .valid     (out_valid[i]),
      .data      (out_data[i*W +: W])
    );
  end

  // Skipping happens independently of in_valid; a skip cycle never accepts
  // because in_ready is low whenever the target is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (flush) begin
      ptr_q <= '0;
    end else if (accept || (SKIP && blocked)) begin
      ptr_q <= inc_ptr(ptr_q);
    end
  end

  // Counter is deliberately untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ptr        = ptr_q;
  assign accept_cnt = cnt_q;
  assign any_valid  = |out_valid;

endmodule
